// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter feeding NREQ requesters into one UART transmit FIFO.
// Optional UART_TX_ARBITER_LOCK_EN adds a per-requester lock for back-to-back bursts.
module uart_tx_arbiter #(
  parameter int NREQ       = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NREQ-1:0]              req,
  input  logic [NREQ*DATA_WIDTH-1:0]   req_data,
`ifdef UART_TX_ARBITER_LOCK_EN
  input  logic [NREQ-1:0]              lock,
`endif
  output logic [NREQ-1:0]              gnt,
  output logic                         uart_wren,
  output logic [DATA_WIDTH-1:0]        uart_wdata,
  input  logic                         uart_tx_full,
  output logic                         busy,
  output logic [$clog2(NREQ)-1:0]      gnt_id
);
  localparam int IDW = $clog2(NREQ);

  typedef enum logic [1:0] {IDLE, WRITE, SETTLE} state_e;

  state_e                              state_q, state_d;
  logic [IDW-1:0]                      gnt_id_q, gnt_id_d, win;
  logic [DATA_WIDTH-1:0]               wdata_q, wdata_d;
  logic [NREQ-1:0][DATA_WIDTH-1:0]     data_arr;
  logic                                found;
  int                                  idx;

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign data_arr[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
  end

  // Search starts one past the last winner so every requester gets a turn.
  always_comb begin
    win   = gnt_id_q;
    found = 1'b0;
    idx   = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(gnt_id_q) + k) % NREQ;
      if (!found && req[idx]) begin
        win   = IDW'(idx);
        found = 1'b1;
      end
    end
`ifdef UART_TX_ARBITER_LOCK_EN
    if (lock[gnt_id_q] && req[gnt_id_q]) win = gnt_id_q;
`endif
  end

  always_comb begin
    state_d  = state_q;
    gnt_id_d = gnt_id_q;
    wdata_d  = wdata_q;
    case (state_q)
      IDLE: begin
        if (|req && !uart_tx_full) begin
          state_d  = WRITE;
          gnt_id_d = win;
          wdata_d  = data_arr[win];
        end
      end
      WRITE:   state_d = SETTLE;
      // SETTLE gives uart_tx_full a cycle to reflect the word just written.
      SETTLE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      gnt_id_q <= IDW'(NREQ - 1);
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      gnt_id_q <= gnt_id_d;
      wdata_q  <= wdata_d;
    end
  end

  always_comb begin
    gnt = '0;
    if (state_q == WRITE) gnt[gnt_id_q] = 1'b1;
  end

  assign uart_wren  = (state_q == WRITE);
  assign busy       = (state_q != IDLE);
  assign uart_wdata = wdata_q;
  assign gnt_id     = gnt_id_q;
endmodule
